// File: rtl/hps_word16_feeder.sv
// hps_word16_feeder
// Producer stage for the 16-bit HPS input PIO. Fabric samples (15 bit) are
// buffered in a small FIFO and presented one at a time as {tog, payload}.
// Every new word flips bit 15, so PIO edge capture on bit 15 tells software
// that a word is ready. Software acknowledges by echoing the toggle value on
// ack_toggle, which arrives asynchronously and is synchronised here.
module hps_word16_feeder #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  input  logic [14:0]              s_data,
  output logic                     s_ready,
  input  logic                     ack_toggle,
  input  logic                     clr_drops,
  output logic [15:0]              word_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] C_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] C_LVL_0  = LW'(0);
  localparam logic [LW-1:0] C_LVL_1  = LW'(1);
  localparam logic [AW-1:0] C_PTR_0  = AW'(0);
  localparam logic [AW-1:0] C_PTR_1  = AW'(1);

  // Presentation FSM: IDLE may pop a word, WAIT holds it until acked.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [14:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [0:0]             r_state;
  logic                   r_tog;
  logic [15:0]            r_word;
  logic [7:0]             r_drop_cnt;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_ack_sync;
  logic [LW-1:0]          w_level_nxt;
  logic [0:0]             w_state_nxt;
  logic [7:0]             w_drop_nxt;

  assign w_ack_sync = r_sync[SYNC_STAGES-1];
  assign s_ready    = ~w_full;
  assign word_out   = r_word;
  assign level      = r_level;
  assign drop_cnt   = r_drop_cnt;

  // FIFO status and handshake decisions; full is judged before any pop this cycle.
  always_comb begin
    w_full  = (r_level == C_FULL);
    w_empty = (r_level == C_LVL_0);
    w_push  = s_valid & ~w_full;
    w_drop  = s_valid & w_full;
    w_pop   = (r_state == S_IDLE) & ~w_empty;
  end

  // Occupancy after this cycle's push/pop combination.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + C_LVL_1;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - C_LVL_1;
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Next presentation state: leave WAIT once the synchronised ack matches tog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_ack_sync == r_tog) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Saturating drop counter; a clear coinciding with a drop leaves a count of one.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (clr_drops) begin
      if (w_drop) begin
        w_drop_nxt = 8'd1;
      end else begin
        w_drop_nxt = 8'd0;
      end
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      w_drop_nxt = r_drop_cnt + 8'd1;
    end else begin
      w_drop_nxt = r_drop_cnt;
    end
  end

  // FIFO storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 15'h0000;
      end
      r_wr_ptr <= C_PTR_0;
      r_rd_ptr <= C_PTR_0;
      r_level  <= C_LVL_0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_data;
        r_wr_ptr        <= r_wr_ptr + C_PTR_1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_1;
      end
      r_level <= w_level_nxt;
    end
  end

  // Bring the software ack bit into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ack_toggle};
    end
  end

  // Presentation: on a pop, flip tog and present the head with the new tog in bit 15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tog   <= 1'b0;
      r_word  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_tog  <= ~r_tog;
        r_word <= {~r_tog, r_mem[r_rd_ptr]};
      end
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_hps_word16_feeder.sv
// Testbench for hps_word16_feeder: directed sequence plus randomised traffic,
// every cycle compared against a queue-based model of the producer/software
// handshake.
module tb_hps_word16_feeder;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic        clk;
  logic        reset_n;
  logic        s_valid;
  logic [14:0] s_data;
  logic        s_ready;
  logic        ack_toggle;
  logic        clr_drops;
  logic [15:0] word_out;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [14:0] mq[$];     // samples accepted but not yet presented
  bit          ack_q[$];  // ack samples in flight through the synchroniser
  bit          m_tog;
  bit          m_busy;    // a word is presented and not yet acknowledged
  logic [15:0] m_word;
  int          m_drop;
  int          n_changes;

  hps_word16_feeder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ack_toggle(ack_toggle),
    .clr_drops (clr_drops),
    .word_out  (word_out),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ack_q.delete();
    for (int i = 0; i < SYNC; i++) ack_q.push_back(1'b0);
    m_tog  = 1'b0;
    m_busy = 1'b0;
    m_word = 16'h0000;
    m_drop = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_word"},  {16'h0, word_out}, {16'h0, m_word});
    chk({tag, "_level"}, {28'h0, level},    mq.size());
    chk({tag, "_drop"},  {24'h0, drop_cnt}, m_drop);
    chk({tag, "_ready"}, {31'h0, s_ready},  (mq.size() != DEPTH) ? 1 : 0);
  endtask

  // Advance one clock with the inputs currently driven, then update the model and compare.
  task automatic step(input string tag);
    bit          full, push, drop, pop, asy, clr;
    logic [14:0] din;
    logic [15:0] prev;
    full = (mq.size() == DEPTH);
    push = s_valid && !full;
    drop = s_valid && full;
    pop  = !m_busy && (mq.size() != 0);
    asy  = ack_q[0];
    din  = s_data;
    clr  = clr_drops;
    ack_q.push_back(ack_toggle);
    prev = word_out;
    @(posedge clk);
    #1;
    void'(ack_q.pop_front());
    if (pop) begin
      m_word = {~m_tog, mq.pop_front()};
      m_tog  = ~m_tog;
      m_busy = 1'b1;
    end else if (m_busy && (asy == m_tog)) begin
      m_busy = 1'b0;
    end
    if (push) mq.push_back(din);
    if (clr) m_drop = drop ? 1 : 0;
    else if (drop && m_drop < 255) m_drop++;
    if (word_out !== prev) n_changes++;
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset(input string tag);
    reset_n    = 1'b0;
    s_valid    = 1'b0;
    clr_drops  = 1'b0;
    ack_toggle = 1'b0;
    #2;
    chk({tag, "_word"},  {16'h0, word_out}, 32'h0);
    chk({tag, "_level"}, {28'h0, level},    32'h0);
    chk({tag, "_ready"}, {31'h0, s_ready},  32'h1);
    chk({tag, "_drop"},  {24'h0, drop_cnt}, 32'h0);
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b1;
    s_valid    = 1'b0;
    s_data     = 15'h0000;
    ack_toggle = 1'b0;
    clr_drops  = 1'b0;
    n_changes  = 0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset, single push, first presentation
    apply_reset("t1_rst");
    s_valid = 1'b1; s_data = 15'h1234;
    chk("t1_ready_before_push", {31'h0, s_ready}, 32'h1);
    step("t1_push");
    chk("t1_level1", {28'h0, level}, 32'h1);
    s_valid = 1'b0;
    step("t1_pop");
    chk("t1_word", {16'h0, word_out}, 32'h9234);
    chk("t1_level0", {28'h0, level}, 32'h0);

    // 2: ack the word, then a second word comes out with bit 15 back to 0
    ack_toggle = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) step("t2_ack");
    s_valid = 1'b1; s_data = 15'h0055;
    step("t2_push");
    s_valid = 1'b0;
    step("t2_pop");
    chk("t2_word", {16'h0, word_out}, 32'h0055);
    for (int i = 0; i < 4; i++) step("t2_hold");

    // 3: no ack, DEPTH+3 back-to-back samples
    apply_reset("t3_rst");
    for (int i = 0; i < DEPTH + 3; i++) begin
      s_valid = 1'b1; s_data = 15'(16'h0100 + i);
      step("t3_fill");
    end
    chk("t3_word",  {16'h0, word_out}, 32'h8100);
    chk("t3_level", {28'h0, level},    DEPTH);
    chk("t3_ready", {31'h0, s_ready},  32'h0);
    chk("t3_drop",  {24'h0, drop_cnt}, 32'h2);

    // 4: saturation and clearing of the drop counter
    for (int i = 0; i < 300; i++) begin
      s_data = 15'($urandom);
      step("t4_sat");
    end
    chk("t4_sat", {24'h0, drop_cnt}, 32'd255);
    clr_drops = 1'b1;
    step("t4_clr_drop");
    chk("t4_clr_with_drop", {24'h0, drop_cnt}, 32'd1);
    s_valid = 1'b0;
    step("t4_clr_alone");
    chk("t4_clr_alone", {24'h0, drop_cnt}, 32'd0);
    clr_drops = 1'b0;
    step("t4_idle");

    // 5: random traffic, software acks every word, upstream respects s_ready
    apply_reset("t5_rst");
    n_changes = 0;
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 3) != 0) && (mq.size() != DEPTH);
      s_data  = 15'($urandom);
      if ((word_out[15] != ack_toggle) && ($urandom_range(0, 2) == 0))
        ack_toggle = word_out[15];
      step("t5_run");
    end
    s_valid = 1'b0;
    chk("t5_drop", {24'h0, drop_cnt}, 32'h0);
    chk("t5_wraps", (n_changes > 3 * DEPTH) ? 32'h1 : 32'h0, 32'h1);

    // 6: reset in the middle of WAIT with tog=1
    apply_reset("t6_pre");
    s_valid = 1'b1; s_data = 15'h7ABC;
    step("t6_push");
    s_data = 15'h0123;
    step("t6_pop");
    s_valid = 1'b0;
    chk("t6_word_pre", {16'h0, word_out}, 32'hFABC);
    step("t6_wait");
    apply_reset("t6_mid");
    for (int i = 0; i < 6; i++) step("t6_quiet");
    chk("t6_quiet_word", {16'h0, word_out}, 32'h0);
    s_valid = 1'b1; s_data = 15'h0001;
    step("t6_push2");
    s_valid = 1'b0;
    step("t6_pop2");
    chk("t6_word_post", {16'h0, word_out}, 32'h8001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
